// File: rtl/dual_port_ram_pkg.sv
// Shared types and constants for the byte-enabled dual-port RAM.
package dual_port_ram_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/dual_port_ram_byte_en_core.sv
// Storage array with per-byte write mask and the first read register (read-first on collision).
module dual_port_ram_byte_en_core
  import dual_port_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             we_i,
  input  logic [ADDR_WIDTH-1:0]            waddr_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_i,
  input  logic                             re_i,
  input  logic [ADDR_WIDTH-1:0]            raddr_i,
  output logic [DATA_WIDTH-1:0]            rdata_o
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  // No reset on the array: zeroing is done by the clear sequence in the top.
  logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_i[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dual_port_ram_byte_en.sv
// Byte-enabled dual-port RAM with post-reset clear (CLEAR -> READY) and 1/2-cycle read latency.
// DUAL_PORT_RAM_BYTE_EN_BYPASS_EN selects write-first on same-address collisions (read-first otherwise).
module dual_port_ram_byte_en
  import dual_port_ram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic                             write_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byte_en,
  input  logic [ADDR_WIDTH-1:0]            raddr,
  input  logic                             read_en,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             dout_valid,
  output logic                             init_busy
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    clearing, wr_fire, rd_fire;
  logic                    core_we;
  logic [ADDR_WIDTH-1:0]   core_waddr;
  logic [DATA_WIDTH-1:0]   core_wdata, core_rdata, rd1_data;
  logic [NB-1:0]           core_be;
  logic                    valid1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter parks on the last address; READY is held until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == LAST_ADDR) state_d = READY;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  assign clearing   = (state_q == CLEAR);
  assign init_busy  = clearing;
  assign wr_fire    = write_en && !clearing;
  assign rd_fire    = read_en && !clearing;

  assign core_we    = clearing || wr_fire;
  assign core_waddr = clearing ? cnt_q : waddr;
  assign core_wdata = clearing ? '0 : din;
  assign core_be    = clearing ? '1 : byte_en;

  dual_port_ram_byte_en_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (core_we),
    .waddr_i (core_waddr),
    .wdata_i (core_wdata),
    .be_i    (core_be),
    .re_i    (rd_fire),
    .raddr_i (raddr),
    .rdata_o (core_rdata)
  );

`ifdef DUAL_PORT_RAM_BYTE_EN_BYPASS_EN
  // Core returns the old word; overlay the colliding write bytes captured with the read.
  logic [NB-1:0]         byp_be_q;
  logic [DATA_WIDTH-1:0] byp_din_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byp_be_q  <= '0;
      byp_din_q <= '0;
    end else if (rd_fire) begin
      byp_be_q  <= (wr_fire && (waddr == raddr)) ? byte_en : '0;
      byp_din_q <= din;
    end
  end

  always_comb begin
    rd1_data = core_rdata;
    for (int b = 0; b < NB; b++) begin
      if (byp_be_q[b]) rd1_data[b*BYTE_WIDTH +: BYTE_WIDTH] = byp_din_q[b*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end
`else
  assign rd1_data = core_rdata;
`endif

  // Pipeline runs regardless of state so in-flight reads always complete.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid1_q <= 1'b0;
    else          valid1_q <= rd_fire;
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign dout       = rd1_data;
    assign dout_valid = valid1_q;
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid2_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        dout_q   <= '0;
        valid2_q <= 1'b0;
      end else begin
        valid2_q <= valid1_q;
        if (valid1_q) dout_q <= rd1_data;
      end
    end

    assign dout       = dout_q;
    assign dout_valid = valid2_q;
  end

endmodule

// File: tb/tb_dual_port_ram_byte_en.sv
// Bench: latency-1 and latency-2 instances driven in parallel, checked against a memory model and scoreboard.
module tb_dual_port_ram_byte_en;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  waddr = '0, raddr = '0, byte_en = '0;
  logic [31:0] din = '0;
  logic        write_en = 1'b0, read_en = 1'b0;

  logic [31:0] dout0, dout1;
  logic        valid0, valid1, busy0, busy1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mdl [16];
  logic [31:0] last_exp [2];
  int          cyc = 0;
  int          clr_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dual_port_ram_byte_en #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n), .waddr(waddr), .din(din), .write_en(write_en),
    .byte_en(byte_en), .raddr(raddr), .read_en(read_en),
    .dout(dout0), .dout_valid(valid0), .init_busy(busy0)
  );

  dual_port_ram_byte_en #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset_n(reset_n), .waddr(waddr), .din(din), .write_en(write_en),
    .byte_en(byte_en), .raddr(raddr), .read_en(read_en),
    .dout(dout1), .dout_valid(valid1), .init_busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic mon(input int p, input logic v, input logic [31:0] d);
    exp_t e;
    int   sz = (p == 0) ? q0.size() : q1.size();
    if (v) begin
      chk($sformatf("l%0d_valid_pending", p + 1), 32'(sz != 0), 32'd1);
      if (sz != 0) begin
        if (p == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("l%0d_rd_data", p + 1), d, e.data);
        chk($sformatf("l%0d_rd_latency", p + 1), cyc, e.due);
        last_exp[p] = e.data;
      end
    end else begin
      chk($sformatf("l%0d_dout_hold", p + 1), d, last_exp[p]);
    end
  endtask

  always @(negedge clk) begin
    mon(0, valid0, dout0);
    mon(1, valid1, dout1);
  end

  task automatic cycle(input logic we, input logic [3:0] wa, input logic [31:0] d,
                       input logic [3:0] be, input logic re, input logic [3:0] ra);
    exp_t e;
    write_en = we; waddr = wa; din = d; byte_en = be; read_en = re; raddr = ra;
    @(posedge clk);
    #1;
    if (clr_cnt < 16) begin
      clr_cnt++;
    end else begin
      if (re) begin
        e.data = mdl[ra];
`ifdef DUAL_PORT_RAM_BYTE_EN_BYPASS_EN
        if (we && wa == ra) e.data = merge(mdl[ra], d, be);
`endif
        e.due = cyc;
        q0.push_back(e);
        e.due = cyc + 1;
        q1.push_back(e);
      end
      if (we) mdl[wa] = merge(mdl[wa], d, be);
    end
    chk("l1_init_busy", 32'(busy0), 32'(clr_cnt < 16));
    chk("l2_init_busy", 32'(busy1), 32'(clr_cnt < 16));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    last_exp[0] = '0;
    last_exp[1] = '0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    #1;
    chk("l1_rst_dout", dout0, 32'd0);
    chk("l2_rst_dout", dout1, 32'd0);
    chk("l1_rst_valid", 32'(valid0), 32'd0);
    chk("l2_rst_valid", 32'(valid1), 32'd0);
    chk("l1_rst_busy", 32'(busy0), 32'd1);
    chk("l2_rst_busy", 32'(busy1), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    clr_cnt = 0;
  endtask

  initial begin
    do_reset();

    // traffic during clear must be ignored
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 32'hFFFF_FFFF, 4'hF, 1'b1, 4'(i));
    for (int i = 0; i < 16; i++) cycle(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(i));
    idle(2);

    // byte-masked writes
    cycle(1'b1, 4'd3, 32'hAABB_CCDD, 4'b1111, 1'b0, 4'd0);
    cycle(1'b1, 4'd3, 32'h1122_3344, 4'b0101, 1'b0, 4'd0);
    cycle(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd3);
    cycle(1'b1, 4'd3, 32'hFFFF_FFFF, 4'b0000, 1'b0, 4'd0);
    cycle(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd3);
    idle(2);

    // same-cycle collision on address 5, then a plain read-back
    cycle(1'b1, 4'd5, 32'hDEAD_BEEF, 4'b1111, 1'b1, 4'd5);
    cycle(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd5);
    cycle(1'b1, 4'd5, 32'h0102_0304, 4'b1001, 1'b1, 4'd5);
    idle(2);

    // back-to-back burst on 0..3
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 8), 32'h5500_0000 + i, 4'hF, 1'b1, 4'(i));
    idle(3);

    for (int i = 0; i < 24; i++)
      cycle(1'($urandom_range(1)), 4'($urandom_range(3)), $urandom, 4'($urandom_range(15)),
            1'($urandom_range(1)), 4'($urandom_range(3)));
    idle(3);

    // reset in the middle of clear, at counter value 7
    do_reset();
    idle(7);
    do_reset();
    idle(16);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(i));
    idle(2);

    // reset while a read is in flight
    cycle(1'b1, 4'd2, 32'hCAFE_F00D, 4'hF, 1'b0, 4'd0);
    cycle(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd2);
    do_reset();
    idle(16);
    cycle(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd2);
    idle(3);

    chk("l1_queue_drained", 32'(q0.size()), 32'd0);
    chk("l2_queue_drained", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_byte_en.md
DUAL_PORT_RAM_BYTE_EN -- requirements
Module: dual_port_ram_byte_en

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address width; depth is 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 32, word width; SHALL be a multiple of 8.
REQ-003 Parameter READ_LATENCY, default 1, read_en-to-dout cycles; legal values are 1 and 2 only.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 waddr  input  ADDR_WIDTH  write word address.
REQ-007 din  input  DATA_WIDTH  write data.
REQ-008 write_en  input  1  write strobe.
REQ-009 byte_en  input  DATA_WIDTH/8  per-byte write mask; bit i gates din[8i+7:8i].
REQ-010 raddr  input  ADDR_WIDTH  read word address.
REQ-011 read_en  input  1  read strobe.
REQ-012 dout  output  DATA_WIDTH  registered read data.
REQ-013 dout_valid  output  1  one-cycle pulse marking new dout.
REQ-014 init_busy  output  1  high while the post-reset clear sequence runs.

Function
REQ-015 The FSM SHALL have two states: CLEAR and READY.
REQ-016 In CLEAR, a counter SHALL write all-zero to address 0,1,...,2**ADDR_WIDTH-1, one address per cycle, then go to READY; CLEAR lasts exactly 2**ADDR_WIDTH cycles.
REQ-017 init_busy SHALL be 1 in CLEAR and 0 in READY.
REQ-018 In CLEAR, write_en and read_en SHALL be ignored, and dout_valid SHALL stay 0.
REQ-019 In READY, write_en=1 at edge N SHALL update only the bytes of mem[waddr] whose byte_en bit is 1; write_en=1 with byte_en all-zero SHALL leave the memory unchanged.
REQ-020 In READY, read_en=1 sampled at edge N SHALL present mem[raddr] on dout, and dout_valid=1, after edge N+READ_LATENCY-1; back-to-back reads SHALL sustain one result per cycle.
REQ-021 dout SHALL hold its last value when no read completes; dout_valid SHALL be 0 in those cycles.
REQ-022 With READ_LATENCY=2, a read issued in the last READY-entry cycle SHALL complete normally; reads in flight SHALL never be dropped except by reset.
REQ-023 Same-cycle read and write to the same address SHALL follow REQ-031/REQ-032; collisions with earlier writes SHALL return the committed data.
REQ-024 The counter SHALL NOT wrap: after reaching the last address it SHALL stop, and the FSM SHALL remain in READY until reset.

Reset
REQ-025 reset_n low SHALL asynchronously force dout=0, dout_valid=0, init_busy=1, state=CLEAR, counter=0, and flush the read pipeline.
REQ-026 Reset asserted mid-CLEAR or mid-READY SHALL restart the full clear from address 0 after deassertion.
REQ-027 The memory array itself SHALL have no reset; it is zeroed only by CLEAR.

Configuration
REQ-028 The macro is DUAL_PORT_RAM_BYTE_EN_BYPASS_EN.
REQ-029 The macro controls same-cycle same-address read/write collision handling in READY.
REQ-030 When the macro is undefined, no bypass logic SHALL exist.
REQ-031 Defined: the read returns the merged word (new din bytes where byte_en=1, old bytes elsewhere), i.e. write-first.
REQ-032 Undefined: the read returns the pre-write word, i.e. read-first.

Structure
REQ-033 The shared package dual_port_ram_pkg SHALL hold the FSM state typedef (CLEAR, READY) and the constant BYTE_WIDTH=8.
REQ-034 The storage array plus the first read register SHALL be the sub-module dual_port_ram_byte_en_core; the FSM, clear counter, bypass and latency pipeline live in the top.

Verification
REQ-035 Scenario: release reset with ADDR_WIDTH=4 -> init_busy=1 for exactly 16 cycles, then 0; a read of every address returns 0x00000000.
REQ-036 Scenario: write 0xAABBCCDD to addr 3 with byte_en=4'b1111, then byte_en=4'b0101 with din 0x11223344 -> a read of addr 3 returns 0xAA22CC44.
REQ-037 Scenario: READY, addr 5 holds 0x0, same-cycle write 0xDEADBEEF (byte_en=4'b1111) and read of addr 5 -> dout=0xDEADBEEF with the macro, 0x00000000 without.
REQ-038 Scenario: READ_LATENCY=2, read_en high for 4 consecutive cycles on addrs 0..3 -> dout_valid high for exactly 4 cycles, starting 2 edges after the first read, with data in order.
REQ-039 Scenario: assert reset_n=0 at clear address 7, release -> init_busy stays 1 for the full 2**ADDR_WIDTH cycles from address 0; dout=0 and dout_valid=0 during reset.
REQ-040 Scenario: write_en and read_en issued during CLEAR -> no dout_valid pulse, and the memory reads all-zero afterwards.
